// File: rtl/flu_frame_stats.sv
// FLU pass-through with one output register stage plus frame/byte/error statistics.
// Define FLU_FRAME_STATS_BYTE_CNT_EN to build the byte counter; otherwise STAT_BYTES is tied to 0.
module flu_frame_stats #(
   parameter int DATA_WIDTH    = 512,
   parameter int SOP_POS_WIDTH = 3,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                              CLK,
   input  logic                              RESET,
   input  logic [DATA_WIDTH-1:0]             RX_DATA,
   input  logic [SOP_POS_WIDTH-1:0]          RX_SOP_POS,
   input  logic [$clog2(DATA_WIDTH/8)-1:0]   RX_EOP_POS,
   input  logic                              RX_SOP,
   input  logic                              RX_EOP,
   input  logic                              RX_SRC_RDY,
   output logic                              RX_DST_RDY,
   output logic [DATA_WIDTH-1:0]             TX_DATA,
   output logic [SOP_POS_WIDTH-1:0]          TX_SOP_POS,
   output logic [$clog2(DATA_WIDTH/8)-1:0]   TX_EOP_POS,
   output logic                              TX_SOP,
   output logic                              TX_EOP,
   output logic                              TX_SRC_RDY,
   input  logic                              TX_DST_RDY,
   input  logic                              STAT_SAMPLE,
   output logic [CNT_WIDTH-1:0]              STAT_FRAMES,
   output logic [CNT_WIDTH-1:0]              STAT_BYTES,
   output logic                              STAT_ERR
);

   localparam int WORD_BYTES = DATA_WIDTH / 8;
   localparam int EOP_W      = $clog2(WORD_BYTES);
   localparam int BLK_SH     = EOP_W - SOP_POS_WIDTH;
   localparam int INC_W      = EOP_W + 2;

   typedef enum logic {ST_IDLE = 1'b0, ST_IN_FRAME = 1'b1} state_t;
   typedef enum logic [2:0] {
      CL_GAP = 3'd0, CL_MID = 3'd1, CL_START = 3'd2, CL_END = 3'd3,
      CL_SINGLE = 3'd4, CL_END_START = 3'd5, CL_ERROR = 3'd6
   } cls_t;

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
      logic [CNT_WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[CNT_WIDTH]) begin
         return {CNT_WIDTH{1'b1}};
      end else begin
         return sum[CNT_WIDTH-1:0];
      end
   endfunction

   logic                  r_tx_src_rdy;
   logic                  w_rx_dst_rdy;
   logic                  w_rx_acc;
   state_t                r_state;
   state_t                w_state_nxt;
   cls_t                  w_cls;
   logic [INC_W-1:0]      w_start;
   logic [INC_W-1:0]      w_end;
   logic                  w_s_le_e;
   logic                  w_frm_inc;
   logic                  w_err_inc;
   logic [CNT_WIDTH-1:0]  r_live_frames;
   logic [CNT_WIDTH-1:0]  r_stat_frames;
   logic [CNT_WIDTH-1:0]  w_frames_sum;
   logic                  r_live_err;
   logic                  r_stat_err;

   assign w_rx_dst_rdy = ~r_tx_src_rdy | TX_DST_RDY;
   assign w_rx_acc     = RX_SRC_RDY & w_rx_dst_rdy;
   assign RX_DST_RDY   = w_rx_dst_rdy;
   assign TX_SRC_RDY   = r_tx_src_rdy;

   // Output register valid: reloads whenever the slot is free or being drained.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_tx_src_rdy <= 1'b0;
      end else if (w_rx_dst_rdy) begin
         r_tx_src_rdy <= RX_SRC_RDY;
      end else begin
         r_tx_src_rdy <= r_tx_src_rdy;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_rx_acc) begin
         TX_DATA    <= RX_DATA;
         TX_SOP_POS <= RX_SOP_POS;
         TX_EOP_POS <= RX_EOP_POS;
         TX_SOP     <= RX_SOP;
         TX_EOP     <= RX_EOP;
      end
   end

   assign w_start  = INC_W'(RX_SOP_POS) << BLK_SH;
   assign w_end    = INC_W'(RX_EOP_POS);
   assign w_s_le_e = (w_start <= w_end);

   // Frame state register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Word classification and next state; state only moves on accepted words.
   always_comb begin
      w_cls       = CL_ERROR;
      w_state_nxt = r_state;
      case ({RX_SOP, RX_EOP})
         2'b00: w_cls = (r_state == ST_IN_FRAME) ? CL_MID : CL_GAP;
         2'b10: w_cls = (r_state == ST_IDLE) ? CL_START : CL_ERROR;
         2'b01: w_cls = (r_state == ST_IN_FRAME) ? CL_END : CL_ERROR;
         2'b11: begin
            if ((r_state == ST_IDLE) && w_s_le_e) begin
               w_cls = CL_SINGLE;
            end else if ((r_state == ST_IN_FRAME) && !w_s_le_e) begin
               w_cls = CL_END_START;
            end else begin
               w_cls = CL_ERROR;
            end
         end
         default: w_cls = CL_ERROR;
      endcase
      if (w_rx_acc) begin
         case (w_cls)
            CL_START, CL_END_START: w_state_nxt = ST_IN_FRAME;
            CL_END, CL_SINGLE:      w_state_nxt = ST_IDLE;
            CL_ERROR: w_state_nxt = (RX_SOP && !(RX_EOP && w_s_le_e)) ? ST_IN_FRAME : ST_IDLE;
            default:                w_state_nxt = r_state;
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Per-word frame and error increments.
   always_comb begin
      w_frm_inc = 1'b0;
      w_err_inc = 1'b0;
      if (w_rx_acc) begin
         case (w_cls)
            CL_END, CL_SINGLE, CL_END_START: w_frm_inc = 1'b1;
            CL_ERROR:                        w_err_inc = 1'b1;
            default:                         w_frm_inc = 1'b0;
         endcase
      end else begin
         w_frm_inc = 1'b0;
      end
   end

   assign w_frames_sum = sat_add(r_live_frames, {{(CNT_WIDTH-1){1'b0}}, w_frm_inc});

   // Live/snapshot frame count and error flag; a sample folds in the same-cycle word.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_live_frames <= {CNT_WIDTH{1'b0}};
         r_stat_frames <= {CNT_WIDTH{1'b0}};
         r_live_err    <= 1'b0;
         r_stat_err    <= 1'b0;
      end else if (STAT_SAMPLE) begin
         r_stat_frames <= w_frames_sum;
         r_stat_err    <= r_live_err | w_err_inc;
         r_live_frames <= {CNT_WIDTH{1'b0}};
         r_live_err    <= 1'b0;
      end else begin
         r_live_frames <= w_frames_sum;
         r_live_err    <= r_live_err | w_err_inc;
      end
   end

   assign STAT_FRAMES = r_stat_frames;
   assign STAT_ERR    = r_stat_err;

`ifdef FLU_FRAME_STATS_BYTE_CNT_EN
   localparam logic [INC_W-1:0] C_WORD = INC_W'(WORD_BYTES);
   localparam logic [INC_W-1:0] C_ONE  = INC_W'(1);

   logic [INC_W-1:0]      w_byte_inc;
   logic [CNT_WIDTH-1:0]  w_bytes_sum;
   logic [CNT_WIDTH-1:0]  r_live_bytes;
   logic [CNT_WIDTH-1:0]  r_stat_bytes;

   // Payload bytes carried by the accepted word for the frame(s) it touches.
   always_comb begin
      w_byte_inc = {INC_W{1'b0}};
      if (w_rx_acc) begin
         case (w_cls)
            CL_MID:       w_byte_inc = C_WORD;
            CL_START:     w_byte_inc = C_WORD - w_start;
            CL_END:       w_byte_inc = w_end + C_ONE;
            CL_SINGLE:    w_byte_inc = w_end + C_ONE - w_start;
            CL_END_START: w_byte_inc = w_end + C_ONE + C_WORD - w_start;
            default:      w_byte_inc = {INC_W{1'b0}};
         endcase
      end else begin
         w_byte_inc = {INC_W{1'b0}};
      end
   end

   assign w_bytes_sum = sat_add(r_live_bytes, CNT_WIDTH'(w_byte_inc));

   // Live/snapshot byte count.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_live_bytes <= {CNT_WIDTH{1'b0}};
         r_stat_bytes <= {CNT_WIDTH{1'b0}};
      end else if (STAT_SAMPLE) begin
         r_stat_bytes <= w_bytes_sum;
         r_live_bytes <= {CNT_WIDTH{1'b0}};
      end else begin
         r_live_bytes <= w_bytes_sum;
      end
   end

   assign STAT_BYTES = r_stat_bytes;
`else
   assign STAT_BYTES = {CNT_WIDTH{1'b0}};
`endif

endmodule
